// File: rtl/reg3_load_arbiter_pkg.sv
// Shared types and defaults for the 3-bit load-register arbiter and its round-robin picker.
package reg3_load_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    COOL = 2'd2
  } state_e;

  localparam int unsigned N_REQ_DEF    = 4;
  localparam int unsigned DW_DEF       = 3;
  localparam int unsigned HOLD_CYC_DEF = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg3_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching circularly from last+1.
module reg3_load_arbiter_rr_pick
  import reg3_load_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned OW    = owner_w(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [OW-1:0]    i_last,
  output logic [OW-1:0]    o_pick,
  output logic             o_valid
);

  logic [OW-1:0] w_idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      w_idx = OW'((32'(i_last) + k) % N_REQ);
      if (i_req[w_idx]) begin
        o_pick  = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg3_load_arbiter.sv
// Round-robin owner of a shared parallel-load register: grants one requester at a time,
// drives the load strobe/data and keeps a shadow of the loaded value and its owner.
module reg3_load_arbiter
  import reg3_load_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = N_REQ_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  localparam int unsigned OW      = owner_w(N_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data,
  output logic [N_REQ-1:0]    ack,
  output logic                pl,
  output logic [DW-1:0]       di_out,
  output logic [DW-1:0]       reg_q,
  output logic [OW-1:0]       owner,
  output logic                busy
);

  localparam int unsigned CW = 3;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [OW-1:0]    r_last;
  logic [OW-1:0]    r_owner;
  logic [DW-1:0]    r_di;
  logic [DW-1:0]    r_q;
  logic [N_REQ-1:0] r_ack;
  logic             r_pl;
  logic             r_busy;

  logic [OW-1:0]    w_pick;
  logic             w_valid;
  logic [DW-1:0]    w_data [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_data[g] = data[g*DW +: DW];
  end

  reg3_load_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  // Grant FSM; data is captured at arbitration so later changes on the bus are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= OW'(N_REQ - 1);
      r_owner <= '0;
      r_di    <= '0;
      r_q     <= '0;
      r_ack   <= '0;
      r_pl    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state <= LOAD;
            r_owner <= w_pick;
            r_di    <= w_data[w_pick];
            r_pl    <= 1'b1;
            r_ack   <= N_REQ'(1) << w_pick;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_pl   <= 1'b0;
          r_ack  <= '0;
          r_q    <= r_di;
          r_last <= r_owner;
          if (HOLD_CYC != 0) begin
            r_state <= COOL;
            r_cnt   <= CW'(HOLD_CYC - 1);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        COOL: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_pl    <= 1'b0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack    = r_ack;
  assign pl     = r_pl;
  assign di_out = r_di;
  assign reg_q  = r_q;
  assign owner  = r_owner;
  assign busy   = r_busy;

endmodule
